// File: rtl/vjtag_bridge_pkg.sv
// Shared definitions for the virtual-JTAG to bus bridge: instruction codes,
// data-register lengths, status-byte bit positions and the IR decoder.
package vjtag_bridge_pkg;

  localparam logic [7:0] IR_BYPASS = 8'h00;
  localparam logic [7:0] IR_ADDR   = 8'h01;
  localparam logic [7:0] IR_WDATA  = 8'h02;
  localparam logic [7:0] IR_RDATA  = 8'h03;
  localparam logic [7:0] IR_STATUS = 8'h04;
  localparam logic [7:0] IR_IDCODE = 8'h05;

  localparam logic [5:0] LEN_BYPASS = 6'd1;
  localparam logic [5:0] LEN_WORD   = 6'd32;
  localparam logic [5:0] LEN_STATUS = 6'd8;
  localparam logic [5:0] CNT_MAX    = 6'd63;

  localparam int ST_PENDING  = 0;
  localparam int ST_LEN_ERR  = 1;
  localparam int ST_OVR_ERR  = 2;
  localparam int ST_BUSY_ERR = 3;

  typedef enum logic [2:0] {
    SEL_BYPASS = 3'd0,
    SEL_ADDR   = 3'd1,
    SEL_WDATA  = 3'd2,
    SEL_RDATA  = 3'd3,
    SEL_STATUS = 3'd4,
    SEL_IDCODE = 3'd5
  } dr_sel_e;

  // Unknown instruction codes fall back to the 1-bit bypass register.
  function automatic dr_sel_e decode_ir(input logic [7:0] ir);
    dr_sel_e sel;
    case (ir)
      IR_BYPASS: sel = SEL_BYPASS;
      IR_ADDR:   sel = SEL_ADDR;
      IR_WDATA:  sel = SEL_WDATA;
      IR_RDATA:  sel = SEL_RDATA;
      IR_STATUS: sel = SEL_STATUS;
      IR_IDCODE: sel = SEL_IDCODE;
      default:   sel = SEL_BYPASS;
    endcase
    return sel;
  endfunction

  function automatic logic [5:0] dr_len(input dr_sel_e sel);
    logic [5:0] len;
    case (sel)
      SEL_ADDR, SEL_WDATA, SEL_RDATA, SEL_IDCODE: len = LEN_WORD;
      SEL_STATUS: len = LEN_STATUS;
      default:    len = LEN_BYPASS;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/vjtag_bus_bridge.sv
// Virtual-JTAG data-register bridge to a simple single-beat bus.
// One 32-bit shift register serves every instruction; the selected
// instruction decides how many of its low bits form the active chain.
import vjtag_bridge_pkg::*;

module vjtag_bus_bridge #(
  parameter logic [31:0] IDCODE   = 32'h5A1A_0001,
  parameter int unsigned ADDR_INC = 4
) (
  input  logic        tck,
  input  logic        rst_n,
  input  logic        tdi,
  output logic        tdo,
  input  logic [7:0]  ir_in,
  output logic [7:0]  ir_out,
  input  logic        virtual_state_cdr,
  input  logic        virtual_state_sdr,
  input  logic        virtual_state_udr,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_wr,
  output logic        bus_rd,
  input  logic        bus_busy,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid
);

  logic [31:0] r_dr;
  logic [5:0]  r_cnt;
  logic        r_tdo;
  logic [7:0]  r_ir_out;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata_q;
  logic        r_rd_pending;
  logic        r_bus_wr;
  logic        r_bus_rd;
  logic        r_busy_err;
  logic        r_ovr_err;
  logic        r_len_err;

  dr_sel_e     w_sel;
  logic [5:0]  w_len;
  logic        w_upd_ok;
  logic        w_len_set;
  logic        w_wr_go;
  logic        w_rd_go;
  logic        w_rsp;
  logic        w_busy_set;
  logic        w_ovr_set;
  logic [2:0]  w_clr;
  logic [7:0]  w_status;
  logic [31:0] w_capture;
  logic [31:0] w_dr_shift;
  logic [31:0] w_addr_inc;

  assign w_sel     = decode_ir(ir_in);
  assign w_len     = dr_len(w_sel);
  assign w_upd_ok  = virtual_state_udr && (r_cnt == w_len);
  assign w_len_set = virtual_state_udr && (r_cnt != w_len);
  assign w_wr_go   = w_upd_ok && (w_sel == SEL_WDATA) && !bus_busy;
  assign w_rd_go   = w_upd_ok && (w_sel == SEL_RDATA) && !bus_busy && !r_rd_pending;
  assign w_rsp     = bus_rvalid && r_rd_pending;
  assign w_busy_set = w_upd_ok && (((w_sel == SEL_WDATA) && bus_busy) ||
                                   ((w_sel == SEL_RDATA) && (bus_busy || r_rd_pending)));
  assign w_ovr_set = virtual_state_cdr && (w_sel == SEL_RDATA) && r_rd_pending;

  // Both a completed write and a completed read advance the address.
  assign w_addr_inc = (r_bus_wr ? 32'(ADDR_INC) : 32'd0) + (w_rsp ? 32'(ADDR_INC) : 32'd0);

  // Status byte assembled from the sticky flags and the read-pending bit
  always_comb begin
    w_status              = 8'h00;
    w_status[ST_PENDING]  = r_rd_pending;
    w_status[ST_LEN_ERR]  = r_len_err;
    w_status[ST_OVR_ERR]  = r_ovr_err;
    w_status[ST_BUSY_ERR] = r_busy_err;
  end

  // Write-one-to-clear mask taken from a valid STATUS update ({busy, ovr, len})
  always_comb begin
    if (w_upd_ok && (w_sel == SEL_STATUS)) begin
      w_clr = {r_dr[ST_BUSY_ERR], r_dr[ST_OVR_ERR], r_dr[ST_LEN_ERR]};
    end else begin
      w_clr = 3'b000;
    end
  end

  // Value loaded into the shift register on capture
  always_comb begin
    case (w_sel)
      SEL_ADDR:   w_capture = r_bus_addr;
      SEL_WDATA:  w_capture = r_bus_wdata;
      SEL_RDATA:  w_capture = r_rdata_q;
      SEL_STATUS: w_capture = {24'h000000, w_status};
      SEL_IDCODE: w_capture = IDCODE;
      default:    w_capture = 32'h0000_0000;
    endcase
  end

  // One shift step: tdi enters at the top of the active chain, bit 0 leaves
  always_comb begin
    case (w_len)
      LEN_WORD:   w_dr_shift = {tdi, r_dr[31:1]};
      LEN_STATUS: w_dr_shift = {r_dr[31:8], tdi, r_dr[7:1]};
      default:    w_dr_shift = {r_dr[31:1], tdi};
    endcase
  end

  // Shift register: parallel capture, then serial shift
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_dr <= 32'h0000_0000;
    end else if (virtual_state_cdr) begin
      r_dr <= w_capture;
    end else if (virtual_state_sdr) begin
      r_dr <= w_dr_shift;
    end
  end

  // Shift counter: cleared on capture, saturating so long scans stay invalid
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 6'd0;
    end else if (virtual_state_cdr) begin
      r_cnt <= 6'd0;
    end else if (virtual_state_sdr && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 6'd1;
    end
  end

  // Serial output and registered status byte
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_tdo    <= 1'b0;
      r_ir_out <= 8'h00;
    end else begin
      r_tdo    <= virtual_state_sdr ? r_dr[0] : 1'b0;
      r_ir_out <= w_status;
    end
  end

  // Bus address: explicit load beats post-increment, wraps naturally
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_addr <= 32'h0000_0000;
    end else if (w_upd_ok && (w_sel == SEL_ADDR)) begin
      r_bus_addr <= r_dr;
    end else begin
      r_bus_addr <= r_bus_addr + w_addr_inc;
    end
  end

  // Write data and the single-cycle request pulses
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_wdata <= 32'h0000_0000;
      r_bus_wr    <= 1'b0;
      r_bus_rd    <= 1'b0;
    end else begin
      if (w_wr_go) begin
        r_bus_wdata <= r_dr;
      end
      r_bus_wr <= w_wr_go;
      r_bus_rd <= w_rd_go;
    end
  end

  // Outstanding read tracking; unsolicited responses are dropped
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_q    <= 32'h0000_0000;
      r_rd_pending <= 1'b0;
    end else if (w_rsp) begin
      r_rdata_q    <= bus_rdata;
      r_rd_pending <= 1'b0;
    end else if (w_rd_go) begin
      r_rd_pending <= 1'b1;
    end
  end

  // Sticky error flags; a same-cycle set overrides the clear
  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_err <= 1'b0;
      r_ovr_err  <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_busy_err <= (r_busy_err & ~w_clr[2]) | w_busy_set;
      r_ovr_err  <= (r_ovr_err  & ~w_clr[1]) | w_ovr_set;
      r_len_err  <= (r_len_err  & ~w_clr[0]) | w_len_set;
    end
  end

  assign tdo       = r_tdo;
  assign ir_out    = r_ir_out;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wr    = r_bus_wr;
  assign bus_rd    = r_bus_rd;

endmodule

// File: tb/tb_vjtag_bus_bridge.sv
// Directed bench for vjtag_bus_bridge: a table of DR scans with
// hand-computed results, followed by read, overflow and reset sequences.
module tb_vjtag_bus_bridge;

  logic        tck = 1'b0;
  logic        rst_n = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic [7:0]  ir_in = 8'h00;
  logic [7:0]  ir_out;
  logic        cdr = 1'b0;
  logic        sdr = 1'b0;
  logic        udr = 1'b0;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wr;
  logic        bus_rd;
  logic        bus_busy = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_rvalid = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // bus monitor state
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  logic [31:0] last_rd_addr = 32'h0;
  logic        prev_wr = 1'b0;
  logic        prev_rd = 1'b0;
  int          both_seen = 0;
  int          long_seen = 0;

  vjtag_bus_bridge #(.IDCODE(32'h5A1A_0001), .ADDR_INC(4)) dut (
    .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo),
    .ir_in(ir_in), .ir_out(ir_out),
    .virtual_state_cdr(cdr), .virtual_state_sdr(sdr), .virtual_state_udr(udr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_busy(bus_busy), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
  );

  always #5 tck = ~tck;

  // Observe request pulses mid-cycle
  always @(negedge tck) begin
    if (bus_wr) begin
      wr_cnt++;
      last_wr_addr = bus_addr;
      last_wr_data = bus_wdata;
    end
    if (bus_rd) begin
      rd_cnt++;
      last_rd_addr = bus_addr;
    end
    if (bus_wr && bus_rd) both_seen++;
    if ((bus_wr && prev_wr) || (bus_rd && prev_rd)) long_seen++;
    prev_wr = bus_wr;
    prev_rd = bus_rd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // capture, shift n bits of din LSB first while collecting tdo, then update
  task automatic scan(input logic [7:0] ir, input int n, input logic [31:0] din,
                      output logic [31:0] dout);
    dout = 32'h0;
    ir_in = ir;
    cdr = 1'b1;
    @(negedge tck);
    cdr = 1'b0;
    for (int i = 0; i < n; i++) begin
      sdr = 1'b1;
      tdi = din[i];
      @(negedge tck);
      dout[i] = tdo;
    end
    sdr = 1'b0;
    tdi = 1'b0;
    udr = 1'b1;
    @(negedge tck);
    udr = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge tck);
  endtask

  typedef struct {
    logic [7:0]  ir;
    int          nbits;
    logic [31:0] din;
    logic        busy;
    logic [31:0] exp_out;
    int          exp_wr;
    logic [31:0] exp_wr_addr;
    logic [31:0] exp_wr_data;
    logic [31:0] exp_addr;
    logic [7:0]  exp_status;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [31:0] dout;
    int wr0, rd0;

    vecs[0]  = '{8'h05, 32, 32'h0000_0000, 1'b0, 32'h5A1A_0001, 0, 32'h0, 32'h0, 32'h0000_0000, 8'h00};
    vecs[1]  = '{8'h01, 32, 32'h0000_1000, 1'b0, 32'h0000_0000, 0, 32'h0, 32'h0, 32'h0000_1000, 8'h00};
    vecs[2]  = '{8'h02, 32, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_1004, 8'h00};
    vecs[3]  = '{8'h02, 32, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 1, 32'h0000_1004, 32'h1234_5678, 32'h0000_1008, 8'h00};
    vecs[4]  = '{8'h01, 32, 32'hFFFF_FFFC, 1'b0, 32'h0000_1008, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 8'h00};
    vecs[5]  = '{8'h02, 32, 32'hA5A5_A5A5, 1'b0, 32'h1234_5678, 1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 32'h0000_0000, 8'h00};
    vecs[6]  = '{8'h02, 32, 32'h1111_1111, 1'b1, 32'hA5A5_A5A5, 0, 32'h0, 32'h0, 32'h0000_0000, 8'h08};
    vecs[7]  = '{8'h02, 31, 32'h2222_2222, 1'b0, 32'h25A5_A5A5, 0, 32'h0, 32'h0, 32'h0000_0000, 8'h0A};
    vecs[8]  = '{8'h04,  8, 32'h0000_000A, 1'b0, 32'h0000_000A, 0, 32'h0, 32'h0, 32'h0000_0000, 8'h00};
    vecs[9]  = '{8'h04,  8, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 32'h0, 32'h0, 32'h0000_0000, 8'h00};
    vecs[10] = '{8'h00,  1, 32'h0000_0001, 1'b0, 32'h0000_0000, 0, 32'h0, 32'h0, 32'h0000_0000, 8'h00};
    vecs[11] = '{8'h7E,  1, 32'h0000_0001, 1'b0, 32'h0000_0000, 0, 32'h0, 32'h0, 32'h0000_0000, 8'h00};
    vecs[12] = '{8'h7E,  2, 32'h0000_0001, 1'b0, 32'h0000_0002, 0, 32'h0, 32'h0, 32'h0000_0000, 8'h02};
    vecs[13] = '{8'h04,  8, 32'h0000_00FF, 1'b0, 32'h0000_0002, 0, 32'h0, 32'h0, 32'h0000_0000, 8'h00};
    vecs[14] = '{8'h01, 32, 32'h0000_2000, 1'b0, 32'h0000_0000, 0, 32'h0, 32'h0, 32'h0000_2000, 8'h00};
    vecs[15] = '{8'h01,  8, 32'h0000_0055, 1'b0, 32'h0000_0000, 0, 32'h0, 32'h0, 32'h0000_2000, 8'h02};
    vecs[16] = '{8'h04,  8, 32'h0000_0002, 1'b0, 32'h0000_0002, 0, 32'h0, 32'h0, 32'h0000_2000, 8'h00};

    // reset state
    cycles(3);
    chk("rst_tdo", {31'h0, tdo}, 32'h0);
    chk("rst_ir_out", {24'h0, ir_out}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_req", {30'h0, bus_wr, bus_rd}, 32'h0);
    rst_n = 1'b1;
    cycles(2);

    // table-driven scans
    for (int i = 0; i < 17; i++) begin
      bus_busy = vecs[i].busy;
      wr0 = wr_cnt;
      scan(vecs[i].ir, vecs[i].nbits, vecs[i].din, dout);
      bus_busy = 1'b0;
      cycles(2);
      chk($sformatf("v%0d_out", i), dout, vecs[i].exp_out);
      chk($sformatf("v%0d_wr", i), wr_cnt - wr0, vecs[i].exp_wr);
      if (vecs[i].exp_wr == 1) begin
        chk($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].exp_wr_addr);
        chk($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].exp_wr_data);
      end
      chk($sformatf("v%0d_addr", i), bus_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_status", i), {24'h0, ir_out}, {24'h0, vecs[i].exp_status});
    end
    chk("tdo_idle", {31'h0, tdo}, 32'h0);

    // read with response three cycles after the update
    scan(8'h01, 32, 32'h0000_3000, dout);
    rd0 = rd_cnt;
    scan(8'h03, 32, 32'h0, dout);
    cycles(1);
    chk("rd_pulse", rd_cnt - rd0, 32'd1);
    chk("rd_addr", last_rd_addr, 32'h0000_3000);
    chk("rd_pending", {24'h0, ir_out}, 32'h01);
    cycles(1);
    bus_rvalid = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    @(negedge tck);
    bus_rvalid = 1'b0;
    bus_rdata = 32'h0;
    cycles(1);
    chk("rd_done_status", {24'h0, ir_out}, 32'h00);
    chk("rd_done_addr", bus_addr, 32'h0000_3004);
    chk("rd_single", rd_cnt - rd0, 32'd1);

    // second read shifts out the first response and leaves a read pending
    scan(8'h03, 32, 32'h0, dout);
    cycles(2);
    chk("rd2_out", dout, 32'hCAFE_F00D);
    // capture while pending: stale data, overflow and busy flagged, no pulse
    rd0 = rd_cnt;
    scan(8'h03, 32, 32'h0, dout);
    cycles(2);
    chk("ovr_out", dout, 32'hCAFE_F00D);
    chk("ovr_status", {24'h0, ir_out}, 32'h0D);
    chk("ovr_no_rd", rd_cnt - rd0, 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata = 32'h0BAD_C0DE;
    @(negedge tck);
    bus_rvalid = 1'b0;
    cycles(1);
    chk("rd3_addr", bus_addr, 32'h0000_3008);
    chk("rd3_status", {24'h0, ir_out}, 32'h0C);
    scan(8'h04, 8, 32'h0000_000C, dout);
    cycles(2);
    chk("w1c_out", dout, 32'h0000_000C);
    chk("w1c_status", {24'h0, ir_out}, 32'h00);

    // reset with a read outstanding, then a late response
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    scan(8'h03, 32, 32'h0, dout);
    cycles(1);
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    cycles(2);
    bus_rvalid = 1'b1;
    bus_rdata = 32'h7777_7777;
    @(negedge tck);
    bus_rvalid = 1'b0;
    cycles(4);
    chk("rst_rd_pulses", rd_cnt - rd0, 32'd1);
    chk("rst_status", {24'h0, ir_out}, 32'h00);
    chk("rst_addr2", bus_addr, 32'h0);
    chk("rst_no_wr", wr_cnt - wr0, 32'd0);
    scan(8'h03, 31, 32'h0, dout);
    cycles(2);
    chk("rst_rdata", dout, 32'h0);
    chk("rst_rd_none", rd_cnt - rd0, 32'd1);
    chk("rst_len_err", {24'h0, ir_out}, 32'h02);

    // request pulse shape over the whole run
    chk("wr_rd_overlap", both_seen, 32'd0);
    chk("pulse_len", long_seen, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vjtag_bus_bridge.md
VJTAG_BUS_BRIDGE -- requirements
Module: vjtag_bus_bridge

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h5A1A_0001, value captured by IDCODE instruction.
REQ-002 SHALL have parameter ADDR_INC, default 4, address post-increment after each completed bus access.
REQ-003 tck  input  1  sole clock, all logic on rising edge; one clock, single domain.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 tdi  input  1  serial data from virtual JTAG.
REQ-006 tdo  output  1  serial data to virtual JTAG.
REQ-007 ir_in  input  8  current virtual instruction.
REQ-008 ir_out  output  8  status byte returned on IR capture.
REQ-009 virtual_state_cdr / virtual_state_sdr / virtual_state_udr  input  1 each  capture / shift / update DR strobes.
REQ-010 bus_addr  output  32  access address; bus_wdata  output  32  write data.
REQ-011 bus_wr / bus_rd  output  1 each  single-cycle access request pulses.
REQ-012 bus_busy  input  1  downstream cannot accept a request this cycle.
REQ-013 bus_rdata  input  32 / bus_rvalid  input  1  read response, one-cycle valid.

Function
REQ-014 Instructions: 0x00 BYPASS (1 bit), 0x01 ADDR (32), 0x02 WDATA (32), 0x03 RDATA (32), 0x04 STATUS (8), 0x05 IDCODE (32); any other code SHALL act as BYPASS.
REQ-015 DR SHALL shift LSB first: on sdr, dr <= {tdi, dr[N-1:1]} for selected length N; tdo SHALL be dr[0] registered; tdo = 0 outside sdr.
REQ-016 Shift bit counter SHALL clear on cdr, increment per sdr cycle, saturate at 63.
REQ-017 On udr, update SHALL occur only if counter equals instruction length; otherwise no update and sticky len_err set.
REQ-018 Capture on cdr: ADDR -> bus_addr; WDATA -> bus_wdata; RDATA -> rdata_q; STATUS -> {4'b0, busy_err, ovr_err, len_err, rd_pending}; IDCODE -> IDCODE; BYPASS -> 0.
REQ-019 Valid udr ADDR SHALL load bus_addr.
REQ-020 Valid udr WDATA: if bus_busy=0, load bus_wdata and pulse bus_wr next cycle, then bus_addr += ADDR_INC; if bus_busy=1, drop write, set busy_err.
REQ-021 Valid udr RDATA: if bus_busy=0 and rd_pending=0, pulse bus_rd next cycle, set rd_pending; else drop, set busy_err.
REQ-022 bus_rvalid with rd_pending SHALL latch bus_rdata into rdata_q, clear rd_pending, bus_addr += ADDR_INC; bus_rvalid without rd_pending SHALL be ignored.
REQ-023 cdr of RDATA while rd_pending=1 SHALL set ovr_err and capture stale rdata_q.
REQ-024 Valid udr STATUS SHALL clear each sticky error whose shifted bit (bit3 busy_err, bit2 ovr_err, bit1 len_err) is 1 (write-one-to-clear); bit0 ignored.
REQ-025 Same-cycle error set and W1C clear: set SHALL win.
REQ-026 bus_addr increment SHALL wrap modulo 2^32.
REQ-027 ir_out SHALL be the STATUS byte, registered every cycle.
REQ-028 bus_wr and bus_rd SHALL never be high together and never longer than one cycle.

Reset
REQ-029 rst_n low SHALL asynchronously clear dr, counter, bus_addr, bus_wdata, rdata_q, rd_pending, all sticky errors, bus_wr, bus_rd, tdo, ir_out to 0.
REQ-030 Reset mid-shift or with read pending SHALL abandon the transaction; no request pulse after release until a new valid udr.

Structure
REQ-031 Package vjtag_bridge_pkg SHALL hold instruction codes, DR lengths, status bit indices.
REQ-032 No sub-module; single module with one shift register sized 32 bits.

Verification
REQ-033 IDCODE: ir_in=0x05, cdr, 32 sdr -> tdo stream equals 32'h5A1A_0001 LSB first.
REQ-034 ADDR=0x1000 then WDATA=0xDEADBEEF, bus_busy=0 -> one bus_wr pulse with addr 0x1000, data 0xDEADBEEF; bus_addr becomes 0x1004.
REQ-035 RDATA udr, bus_rvalid 3 cycles later with bus_rdata=0xCAFEF00D -> one bus_rd pulse, rd_pending 1->0, next RDATA capture shifts out 0xCAFEF00D.
REQ-036 WDATA udr after 31 shifts -> no bus_wr, status reads 0x02; STATUS write 0x02 -> status 0x00.
REQ-037 bus_addr=0xFFFFFFFC, write -> bus_addr wraps to 0x00000000; write with bus_busy=1 -> no bus_wr, busy_err set.
REQ-038 rst_n low during read pending, then rvalid after release -> rdata_q stays 0, rd_pending 0, no error.
